// File: rtl/channel_readout_packer.sv
// Readout stage for one ring-buffer channel. It frames the returned samples as
// header, data and trailer words and queues them in a FIFO for the host stream.
module channel_readout_packer #(
   parameter int WIDTH     = 12,
   parameter int SIZE      = 12,
   parameter int FIFO_LOG2 = 4,
   parameter int TIMEOUT   = 4095
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       chan_id,
   input  logic [SIZE-1:0]  how_many,
   output logic             read_request,
   input  logic             ro_enable,
   input  logic             rodone_n,
   input  logic [WIDTH-1:0] sample_in,
   output logic [15:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overflow
);

   // state   | meaning
   // IDLE    | waiting for start
   // HDR0    | push {A, how_many}
   // HDR1    | push {B, 00, chan_id}
   // COLLECT | read_request high, push one data word per valid sample
   // TRL     | push {E|F, count}, then back to IDLE
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_COLLECT,
      S_TRL
   } state_t;

   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam logic [FIFO_LOG2:0] FULL_LVL = {1'b1, {FIFO_LOG2{1'b0}}};
   localparam logic [TW-1:0]      TO_LAST  = TW'(TIMEOUT - 1);

   state_t                 state_q, state_d;
   logic [SIZE-1:0]        how_many_q, how_many_d;
   logic [3:0]             chan_q, chan_d;
   logic [SIZE-1:0]        count_q, count_d;
   logic [TW-1:0]          timeout_q, timeout_d;
   logic                   timed_out_q, timed_out_d;
   logic                   overflow_q, overflow_d;
   logic                   read_request_q, read_request_d;

   logic [15:0]            mem_q [DEPTH];
   logic [FIFO_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [FIFO_LOG2:0]     level_q, level_d;
   logic [15:0]            out_data_q, out_data_d;

   logic                   pop;
   logic                   can_push;
   logic                   push_req;
   logic                   do_push;
   logic [15:0]            push_data;
   logic                   sample_ok;

   assign pop       = (level_q != '0) && out_ready;
   assign can_push  = (level_q != FULL_LVL) || pop;
   assign sample_ok = ro_enable && rodone_n && read_request_q;
   assign do_push   = push_req && can_push;

   always_comb begin
      state_d     = state_q;
      how_many_d  = how_many_q;
      chan_d      = chan_q;
      count_d     = count_q;
      timeout_d   = timeout_q;
      timed_out_d = timed_out_q;
      overflow_d  = overflow_q;
      push_req    = 1'b0;
      push_data   = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               how_many_d  = how_many;
               chan_d      = chan_id;
               count_d     = '0;
               timeout_d   = '0;
               timed_out_d = 1'b0;
               overflow_d  = 1'b0;
               state_d     = S_HDR0;
            end
         end
         S_HDR0: begin
            push_req  = 1'b1;
            push_data = {4'hA, how_many_q};
            if (can_push) state_d = S_HDR1;
         end
         S_HDR1: begin
            push_req  = 1'b1;
            push_data = {4'hB, 8'h00, chan_q};
            if (can_push) state_d = (how_many_q != '0) ? S_COLLECT : S_TRL;
         end
         S_COLLECT: begin
            if ((count_q == how_many_q) || (ro_enable && !rodone_n)) begin
               state_d = S_TRL;
            end else if (sample_ok) begin
               // a dropped sample is still counted to stay aligned with the channel
               push_req  = 1'b1;
               push_data = {4'h0, sample_in};
               count_d   = count_q + 1'b1;
               timeout_d = '0;
               if (!can_push) overflow_d = 1'b1;
            end else if (timeout_q == TO_LAST) begin
               state_d     = S_TRL;
               timed_out_d = 1'b1;
            end else begin
               timeout_d = timeout_q + 1'b1;
            end
         end
         S_TRL: begin
            push_req  = 1'b1;
            push_data = {(timed_out_q ? 4'hF : 4'hE), count_q};
            if (can_push) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign read_request_d = (state_d == S_COLLECT);

   always_comb begin
      wr_ptr_d   = wr_ptr_q + FIFO_LOG2'(do_push);
      rd_ptr_d   = rd_ptr_q + FIFO_LOG2'(pop);
      level_d    = level_q + (FIFO_LOG2 + 1)'(do_push) - (FIFO_LOG2 + 1)'(pop);
      out_data_d = out_data_q;
      // head slot may be the one being written this cycle (empty or drained FIFO)
      if (level_d != '0) begin
         out_data_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         how_many_q     <= '0;
         chan_q         <= '0;
         count_q        <= '0;
         timeout_q      <= '0;
         timed_out_q    <= 1'b0;
         overflow_q     <= 1'b0;
         read_request_q <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         out_data_q     <= '0;
      end else begin
         state_q        <= state_d;
         how_many_q     <= how_many_d;
         chan_q         <= chan_d;
         count_q        <= count_d;
         timeout_q      <= timeout_d;
         timed_out_q    <= timed_out_d;
         overflow_q     <= overflow_d;
         read_request_q <= read_request_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         out_data_q     <= out_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign read_request = read_request_q;
   assign busy         = (state_q != S_IDLE);
   assign overflow     = overflow_q;
   assign out_valid    = (level_q != '0);
   assign out_data     = out_data_q;

endmodule

// File: tb/tb_channel_readout_packer.sv
// Directed bench for channel_readout_packer with a behavioural channel driver
// and a word collector on the output stream.
module tb_channel_readout_packer;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [3:0]  chan_id;
   logic [11:0] how_many;
   logic        read_request, ro_enable, rodone_n;
   logic [11:0] sample_in;
   logic [15:0] out_data;
   logic        out_valid, out_ready, busy, overflow;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] got[$];
   logic [15:0] exp_q[$];
   int          idx, chan_mode, done_after, rr_cycles;
   bit          rr_seen, rr_prev, fall_seen;
   logic        busy_at_fall;

   always #5 clk = ~clk;

   channel_readout_packer #(
      .WIDTH(12), .SIZE(12), .FIFO_LOG2(4), .TIMEOUT(16)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .chan_id(chan_id),
      .how_many(how_many), .read_request(read_request), .ro_enable(ro_enable),
      .rodone_n(rodone_n), .sample_in(sample_in), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .overflow(overflow)
   );

   // One cycle: log the handshake about to happen, move to the falling edge,
   // then drive the channel. Channel modes: 0 normal, 1 done after N, 2 silent.
   task automatic step();
      if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);
      @(negedge clk);
      if (read_request === 1'b1) begin
         rr_seen = 1'b1;
         rr_cycles++;
      end
      if (rr_prev && read_request === 1'b0 && !fall_seen) begin
         fall_seen    = 1'b1;
         busy_at_fall = busy;
      end
      rr_prev = (read_request === 1'b1);
      if (read_request !== 1'b1 || chan_mode == 2) begin
         ro_enable = 1'b0;
         rodone_n  = 1'b1;
      end else if (chan_mode == 1 && idx >= done_after) begin
         ro_enable = 1'b1;
         rodone_n  = 1'b0;
      end else begin
         ro_enable = 1'b1;
         rodone_n  = 1'b1;
         sample_in = 12'(32'h111 * (idx + 1));
         idx++;
      end
   endtask

   task automatic init_test();
      got.delete();
      exp_q.delete();
      idx       = 0;
      chan_mode = 0;
      rr_cycles = 0;
      rr_seen   = 1'b0;
      rr_prev   = 1'b0;
      fall_seen = 1'b0;
   endtask

   task automatic pulse_start(input logic [3:0] ch, input logic [11:0] hm);
      start    = 1'b1;
      chan_id  = ch;
      how_many = hm;
      step();
      start    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; out_ready = 1'b0; ro_enable = 1'b0;
      rodone_n = 1'b1; sample_in = '0; chan_id = '0; how_many = '0;
      init_test();
      step(); step();
      reset = 1'b0;
      step();
      n_checks++; if (read_request !== 1'b0) $display("FAIL rst_rr: got %b want 0", read_request); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (out_data !== 16'h0) $display("FAIL rst_data: got %h want 0000", out_data); else n_pass++;
   endtask

   task automatic test_basic();
      init_test();
      out_ready = 1'b1;
      pulse_start(4'd3, 12'd4);
      n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
      step();
      n_checks++; if (read_request !== 1'b0) $display("FAIL basic_rr_c2: got %b want 0", read_request); else n_pass++;
      step();
      n_checks++; if (read_request !== 1'b1) $display("FAIL basic_rr_c3: got %b want 1", read_request); else n_pass++;
      repeat (25) step();
      exp_q = '{16'hA004, 16'hB003, 16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'hE004};
      n_checks++; if (got.size() != exp_q.size()) $display("FAIL basic_len: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [15:0] w;
         w = (i < got.size()) ? got[i] : 16'hxxxx;
         n_checks++; if (w !== exp_q[i]) $display("FAIL basic_word%0d: got %h want %h", i, w, exp_q[i]); else n_pass++;
      end
      n_checks++; if (overflow !== 1'b0) $display("FAIL basic_ovf: got %b want 0", overflow); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL basic_idle: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_zero();
      init_test();
      out_ready = 1'b1;
      pulse_start(4'd5, 12'd0);
      repeat (15) step();
      exp_q = '{16'hA000, 16'hB005, 16'hE000};
      n_checks++; if (got.size() != exp_q.size()) $display("FAIL zero_len: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [15:0] w;
         w = (i < got.size()) ? got[i] : 16'hxxxx;
         n_checks++; if (w !== exp_q[i]) $display("FAIL zero_word%0d: got %h want %h", i, w, exp_q[i]); else n_pass++;
      end
      n_checks++; if (rr_seen !== 1'b0) $display("FAIL zero_rr: got %b want 0", rr_seen); else n_pass++;
   endtask

   task automatic test_overflow();
      init_test();
      out_ready = 1'b0;
      pulse_start(4'd7, 12'd20);
      repeat (40) step();
      n_checks++; if (got.size() != 0) $display("FAIL ovf_notaken: got %0d want 0", got.size()); else n_pass++;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL ovf_valid: got %b want 1", out_valid); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL ovf_stall: got %b want 1", busy); else n_pass++;
      n_checks++; if (out_data !== 16'hA014) $display("FAIL ovf_head: got %h want A014", out_data); else n_pass++;
      out_ready = 1'b1;
      repeat (40) step();
      exp_q.push_back(16'hA014);
      exp_q.push_back(16'hB007);
      for (int i = 1; i <= 14; i++) begin
         logic [11:0] s;
         s = 12'(32'h111 * i);
         exp_q.push_back({4'h0, s});
      end
      exp_q.push_back(16'hE014);
      n_checks++; if (got.size() != exp_q.size()) $display("FAIL ovf_len: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [15:0] w;
         w = (i < got.size()) ? got[i] : 16'hxxxx;
         n_checks++; if (w !== exp_q[i]) $display("FAIL ovf_word%0d: got %h want %h", i, w, exp_q[i]); else n_pass++;
      end
      n_checks++; if (busy !== 1'b0) $display("FAIL ovf_idle: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_done_early();
      init_test();
      chan_mode  = 1;
      done_after = 5;
      out_ready  = 1'b1;
      pulse_start(4'd2, 12'd8);
      n_checks++; if (overflow !== 1'b0) $display("FAIL done_ovf_clr: got %b want 0", overflow); else n_pass++;
      repeat (25) step();
      exp_q = '{16'hA008, 16'hB002, 16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0555, 16'hE005};
      n_checks++; if (got.size() != exp_q.size()) $display("FAIL done_len: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [15:0] w;
         w = (i < got.size()) ? got[i] : 16'hxxxx;
         n_checks++; if (w !== exp_q[i]) $display("FAIL done_word%0d: got %h want %h", i, w, exp_q[i]); else n_pass++;
      end
      n_checks++; if (fall_seen !== 1'b1) $display("FAIL done_rr_fall: got %b want 1", fall_seen); else n_pass++;
      n_checks++; if (busy_at_fall !== 1'b1) $display("FAIL done_rr_trl: got %b want 1", busy_at_fall); else n_pass++;
   endtask

   task automatic test_timeout();
      init_test();
      chan_mode = 2;
      out_ready = 1'b1;
      pulse_start(4'd9, 12'd8);
      repeat (40) step();
      exp_q = '{16'hA008, 16'hB009, 16'hF000};
      n_checks++; if (got.size() != exp_q.size()) $display("FAIL to_len: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [15:0] w;
         w = (i < got.size()) ? got[i] : 16'hxxxx;
         n_checks++; if (w !== exp_q[i]) $display("FAIL to_word%0d: got %h want %h", i, w, exp_q[i]); else n_pass++;
      end
      n_checks++; if (rr_cycles != 16) $display("FAIL to_cycles: got %0d want 16", rr_cycles); else n_pass++;
   endtask

   task automatic test_back_to_back();
      init_test();
      out_ready = 1'b1;
      pulse_start(4'd4, 12'd2);
      step();
      start    = 1'b1;
      chan_id  = 4'd8;
      how_many = 12'd5;
      step();
      start    = 1'b0;
      repeat (20) step();
      exp_q = '{16'hA002, 16'hB004, 16'h0111, 16'h0222, 16'hE002};
      n_checks++; if (got.size() != exp_q.size()) $display("FAIL b2b_len: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [15:0] w;
         w = (i < got.size()) ? got[i] : 16'hxxxx;
         n_checks++; if (w !== exp_q[i]) $display("FAIL b2b_word%0d: got %h want %h", i, w, exp_q[i]); else n_pass++;
      end
      n_checks++; if (busy !== 1'b0) $display("FAIL b2b_idle: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_reset_mid();
      init_test();
      out_ready = 1'b0;
      pulse_start(4'd1, 12'd8);
      repeat (5) step();
      n_checks++; if (read_request !== 1'b1) $display("FAIL mid_collect: got %b want 1", read_request); else n_pass++;
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++; if (read_request !== 1'b0) $display("FAIL mid_rr: got %b want 0", read_request); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL mid_ovf: got %b want 0", overflow); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (out_data !== 16'h0) $display("FAIL mid_data: got %h want 0000", out_data); else n_pass++;
      out_ready = 1'b1;
      repeat (10) step();
      n_checks++; if (got.size() != 0) $display("FAIL mid_nowords: got %0d want 0", got.size()); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_idle: got %b want 0", busy); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_overflow();
      test_done_early();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/channel_readout_packer.md
# channel_readout_packer

Downstream readout stage for one `single_channel` instance. Runs a readout transaction on the channel and frames the returned 12-bit ring-buffer samples into 16-bit words: header, data, trailer. Drives the channel's `read_request` and watches its `RO_ENABLE_out` and `RODONE_n_out` strobes. Words are buffered in an internal FIFO and presented on a valid/ready stream to the SPI/host side.

## Interface
Parameters:
- `WIDTH`, 12, sample width; fixed at 12 for this framing.
- `SIZE`, 12, width of `how_many` and of the sample counter.
- `FIFO_LOG2`, 4, output FIFO depth is 2^FIFO_LOG2 = 16 words.
- `TIMEOUT`, 4095, cycles to wait in COLLECT for the next sample before aborting.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; same clock as the channel's `clk`.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to read out one channel.
- `chan_id`  in  4  channel number; latched on an accepted `start`.
- `how_many`  in  SIZE  number of samples to read; latched on an accepted `start`.
- `read_request`  out  1  to the channel's `read_request`.
- `ro_enable`  in  1  from the channel's `RO_ENABLE_out`.
- `rodone_n`  in  1  from the channel's `RODONE_n_out`; low means done.
- `sample_in`  in  WIDTH  from the channel's `data_out`.
- `out_data`  out  16  head-of-FIFO word.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts `out_data`.
- `busy`  out  1  state is not IDLE.
- `overflow`  out  1  sticky; set when a sample is dropped; cleared by an accepted `start`.

## Operation
- States: IDLE, HDR0, HDR1, COLLECT, TRL.
- IDLE:
  - `start` accepted only here; `start` while `busy` is ignored.
  - On accept: latch `chan_id` and `how_many`, clear the sample counter, timeout counter and `overflow`, then go to HDR0.
- HDR0: push `{4'hA, how_many}`.
- HDR1:
  - Push `{4'hB, 8'h00, chan_id}`.
  - Next state is COLLECT if `how_many != 0`, otherwise TRL.
- COLLECT:
  - `read_request` = 1.
  - Sample valid condition: `ro_enable & rodone_n & read_request`.
  - On each valid sample: push `{4'h0, sample_in}`, increment the counter, reset the timeout counter.
  - Leave for TRL when any of these holds:
    - the counter reaches `how_many`;
    - `ro_enable & ~rodone_n`;
    - the timeout counter reaches `TIMEOUT`.
- TRL:
  - Push `{4'hE, count}` on normal end, or `{4'hF, count}` on timeout.
  - Then go to IDLE.
- Header and trailer pushes are never dropped. If the FIFO is full, the state holds until there is space.
- Data pushes are dropped when the FIFO is full. The drop sets `overflow`, but the counter still increments so that counting stays aligned with the channel.
- FIFO:
  - Push is accepted when not full, or when not full after the same-cycle pop (`out_valid & out_ready`).
  - Simultaneous push and pop leaves the occupancy unchanged.
- Counter width is SIZE. A `how_many` value of 2^SIZE-1 is the largest readout.

## Timing
- Reset values: `read_request`=0, `busy`=0, `overflow`=0, `out_valid`=0, `out_data`=0. State is IDLE, FIFO empty, counters 0.
- `start` is sampled at edge 0. HDR0 runs in cycle 1 and HDR1 in cycle 2.
- `read_request` is registered and goes high in cycle 3, on entry to COLLECT.
- A sample seen at edge n appears in the FIFO at edge n+1. With an empty FIFO and `out_ready`=1, `out_valid` rises 1 cycle after the push.
- `read_request` drops on the same edge that enters TRL. Samples in the cycle where the end condition is met are not taken.
- `out_data` is registered FIFO head data. It is stable while `out_valid & ~out_ready`.
- Reset mid-transaction:
  - Returns to IDLE next edge, discards the FIFO, drops `read_request`.
  - No trailer is emitted.

## Test plan
- `start`, `chan_id`=3, `how_many`=4, channel returns 0x111..0x444, `out_ready`=1 -> stream A004, B003, 0111, 0222, 0333, 0444, E004; `overflow`=0.
- `how_many`=0 -> A000, B0<id>, E000; `read_request` never asserted.
- `how_many`=20, `out_ready`=0 throughout -> FIFO holds 16 words: A014, B0.., 14 samples. `overflow`=1. FSM stalls in TRL until `out_ready`=1, then E014 follows.
- `how_many`=8, `rodone_n` goes low after 5 samples -> trailer E005; `read_request` deasserts on the same edge as the TRL entry.
- `how_many`=8, `ro_enable` never rises, `TIMEOUT`=16 -> after 16 COLLECT cycles the stream is A008, B0.., F000.
- `reset` pulsed during COLLECT; second `start` pulsed while busy -> after reset all outputs are 0 and the FIFO is empty. The ignored `start` produces no extra header.
